// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: length-prefixed big-endian words into instruction memory; holds cpu_run low until done.
// Optional trailing XOR checksum byte enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_FLUSH,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [31:0]           CAP  = 32'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                state_q, state_d, done_state;
  logic [15:0]           len_q, len_d;
  logic [31:0]           asm_q, asm_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic                  rdy_q, rdy_d;
  logic                  xfer;
  logic [15:0]           len_full;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  assign xfer     = rx_valid && rdy_q;
  assign len_full = {len_q[15:8], rx_data};

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign done_state = S_CHK;
`else
  assign done_state = S_RUN;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      wc_q    <= '0;
      rdy_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wc_q    <= wc_d;
      rdy_q   <= rdy_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // The count advances at the end of the write cycle, so imem_addr used the pre-write count.
    wc_d    = wc_q + (ADDR_WIDTH+1)'(we_q);
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          cnt_d      = '0;
          if (len_full == 16'd0)       state_d = done_state;
          else if (32'(len_full) > CAP) state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d = {asm_q[23:0], rx_data};
          cnt_d = cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {asm_q[23:0], rx_data};
            addr_d  = BASE + wc_q[ADDR_WIDTH-1:0];
            // Last word: stop accepting bytes while its write is still in flight.
            if (32'(wc_q) + 32'd1 == 32'(len_q)) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = done_state;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (rx_data == xor_q) ? S_RUN : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase

    rdy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA)
`ifdef INSTR_LOADER_CHECKSUM_EN
            || (state_d == S_CHK)
`endif
            ;
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  assign cpu_run    = (state_q == S_RUN);
  assign load_done  = (state_q == S_RUN);
  assign load_error = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (ADDR_WIDTH=8, BASE_ADDR=0).
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_run, load_done, load_error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  int errors = 0;
  int checks = 0;
  int exp_words = 0;
  int run_early = 0;
  int overlap = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  instr_mem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .load_done(load_done), .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
      if (cpu_run && imem_we) overlap++;
      if (cpu_run && (wr_addr.size() < exp_words)) run_early++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    run_early = 0;
    overlap = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: byte %02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 8;
    if (rx_ready !== 1'b0)    begin errors++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
    if (imem_we !== 1'b0)     begin errors++; $display("FAIL rst_imem_we got %b want 0", imem_we); end
    if (imem_addr !== 8'h00)  begin errors++; $display("FAIL rst_imem_addr got %h want 00", imem_addr); end
    if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_imem_wdata got %h want 0", imem_wdata); end
    if (cpu_run !== 1'b0)     begin errors++; $display("FAIL rst_cpu_run got %b want 0", cpu_run); end
    if (load_done !== 1'b0)   begin errors++; $display("FAIL rst_load_done got %b want 0", load_done); end
    if (load_error !== 1'b0)  begin errors++; $display("FAIL rst_load_error got %b want 0", load_error); end
    if (word_count !== 9'd0)  begin errors++; $display("FAIL rst_word_count got %0d want 0", word_count); end
    do_reset();
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b want 1", rx_ready); end
  endtask

  task automatic test_single_word();
    do_reset();
    exp_words = 1;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    checks += 2;
    if (imem_we !== 1'b1)   begin errors++; $display("FAIL single_we_latency got %b want 1", imem_we); end
    if (imem_addr !== 8'd0) begin errors++; $display("FAIL single_addr got %h want 00", imem_addr); end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    idle(4);
    checks += 7;
    if (wr_addr.size() != 1) begin errors++; $display("FAIL single_nwrites got %0d want 1", wr_addr.size()); end
    else if (wr_data[0] !== 32'h12345678) begin errors++; $display("FAIL single_wdata got %h want 12345678", wr_data[0]); end
    if (cpu_run !== 1'b1)    begin errors++; $display("FAIL single_cpu_run got %b want 1", cpu_run); end
    if (load_done !== 1'b1)  begin errors++; $display("FAIL single_load_done got %b want 1", load_done); end
    if (word_count !== 9'd1) begin errors++; $display("FAIL single_word_count got %0d want 1", word_count); end
    if (rx_ready !== 1'b0)   begin errors++; $display("FAIL single_rx_ready got %b want 0", rx_ready); end
    if (load_error !== 1'b0) begin errors++; $display("FAIL single_load_error got %b want 0", load_error); end
    if (overlap != 0)        begin errors++; $display("FAIL single_run_during_write got %0d want 0", overlap); end
  endtask

  task automatic test_gapped_stream();
    do_reset();
    exp_words = 3;
    send_byte(8'h00); idle(1); send_byte(8'h03); idle(1);
    for (int w = 1; w <= 3; w++) begin
      send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
      send_byte(8'h00); idle(1); send_byte(8'(w)); idle(1);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(4);
    checks++;
    if (wr_addr.size() != 3) begin
      errors++; $display("FAIL gap_nwrites got %0d want 3", wr_addr.size());
    end else begin
      for (int w = 0; w < 3; w++) begin
        checks += 2;
        if (wr_addr[w] !== 8'(w)) begin errors++; $display("FAIL gap_addr%0d got %h want %h", w, wr_addr[w], 8'(w)); end
        if (wr_data[w] !== 32'(w + 1)) begin errors++; $display("FAIL gap_wdata%0d got %h want %h", w, wr_data[w], 32'(w + 1)); end
      end
    end
    checks += 4;
    if (run_early != 0)      begin errors++; $display("FAIL gap_run_early got %0d want 0", run_early); end
    if (overlap != 0)        begin errors++; $display("FAIL gap_run_during_write got %0d want 0", overlap); end
    if (cpu_run !== 1'b1)    begin errors++; $display("FAIL gap_cpu_run got %b want 1", cpu_run); end
    if (word_count !== 9'd3) begin errors++; $display("FAIL gap_word_count got %0d want 3", word_count); end
  endtask

  task automatic test_oversize();
    do_reset();
    exp_words = 0;
    send_byte(8'h01); send_byte(8'h01);
    idle(4);
    checks += 5;
    if (load_error !== 1'b1)  begin errors++; $display("FAIL over_load_error got %b want 1", load_error); end
    if (rx_ready !== 1'b0)    begin errors++; $display("FAIL over_rx_ready got %b want 0", rx_ready); end
    if (cpu_run !== 1'b0)     begin errors++; $display("FAIL over_cpu_run got %b want 0", cpu_run); end
    if (wr_addr.size() != 0)  begin errors++; $display("FAIL over_nwrites got %0d want 0", wr_addr.size()); end
    if (load_done !== 1'b0)   begin errors++; $display("FAIL over_load_done got %b want 0", load_done); end
  endtask

  task automatic test_zero_length();
    do_reset();
    exp_words = 0;
    send_byte(8'h00); send_byte(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
    idle(2);
    checks++;
    if (cpu_run !== 1'b0) begin errors++; $display("FAIL zero_wait_chk got %b want 0", cpu_run); end
    send_byte(8'h00);
`endif
    idle(3);
    checks += 3;
    if (cpu_run !== 1'b1)    begin errors++; $display("FAIL zero_cpu_run got %b want 1", cpu_run); end
    if (word_count !== 9'd0) begin errors++; $display("FAIL zero_word_count got %0d want 0", word_count); end
    if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_nwrites got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    exp_words = 2;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    checks++;
    if (wr_addr.size() != 1) begin errors++; $display("FAIL mid_first_write got %0d want 1", wr_addr.size()); end
    #2;
    reset = 1'b1;
    #1;
    checks += 2;
    if (word_count !== 9'd0) begin errors++; $display("FAIL mid_async_clear got %0d want 0", word_count); end
    if (rx_ready !== 1'b0)   begin errors++; $display("FAIL mid_async_ready got %b want 0", rx_ready); end
    do_reset();
    exp_words = 1;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    idle(4);
    checks += 2;
    if (wr_addr.size() != 1) begin
      errors++; $display("FAIL mid_nwrites got %0d want 1", wr_addr.size());
    end else begin
      checks += 2;
      if (wr_addr[0] !== 8'h00)        begin errors++; $display("FAIL mid_addr got %h want 00", wr_addr[0]); end
      if (wr_data[0] !== 32'h11223344) begin errors++; $display("FAIL mid_wdata got %h want 11223344", wr_data[0]); end
    end
    if (word_count !== 9'd1) begin errors++; $display("FAIL mid_word_count got %0d want 1", word_count); end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      exp_words = 1;
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
      idle(2);
      checks++;
      if (cpu_run !== 1'b0) begin errors++; $display("FAIL chk_wait%0d got %b want 0", k, cpu_run); end
      send_byte(k == 0 ? 8'h00 : 8'h01);
      idle(2);
      checks += 3;
      if (cpu_run !== (k == 0))    begin errors++; $display("FAIL chk_cpu_run%0d got %b want %b", k, cpu_run, k == 0); end
      if (load_error !== (k == 1)) begin errors++; $display("FAIL chk_load_error%0d got %b want %b", k, load_error, k == 1); end
      if (wr_data.size() != 1 || wr_data[0] !== 32'hAA550FF0) begin
        errors++; $display("FAIL chk_wdata%0d nwrites %0d want 1 of AA550FF0", k, wr_data.size());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_gapped_stream();
    test_oversize();
    test_zero_length();
    test_reset_mid_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory; the fetch stage is the reader.
- Receives a byte stream and assembles big-endian 32-bit instruction words. Writes each word to consecutive instruction-memory addresses.
- Holds the processor stalled (cpu_run=0) until the whole program has been loaded. Sits between the host byte link and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.
- BASE_ADDR, 0, word address where the first instruction is written.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  instruction-memory word address
- imem_wdata  output  32  instruction word to write
- cpu_run  output  1  pipeline enable; 0 while loading
- load_done  output  1  program fully loaded (sticky)
- load_error  output  1  protocol error (sticky until reset)
- word_count  output  ADDR_WIDTH+1  words written so far

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. While reset is asserted, all state clears immediately.
- Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_run=0, load_done=0, load_error=0, word_count=0. The FSM goes to LEN_HI.
  - rx_ready rises in the first cycle after reset deasserts.
- Byte transfer occurs on a cycle with rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes (MSB first), then an optional checksum byte.
- FSM:
  - LEN_HI: on transfer, latch length[15:8] and go to LEN_LO.
  - LEN_LO: on transfer, latch length[7:0], then:
    - N=0: go to CHK (feature on) or RUN.
    - N > 2^ADDR_WIDTH - (BASE_ADDR): go to ERR.
    - Otherwise go to DATA.
  - DATA: shift each byte into a 32-bit assembler and count bytes 0..3 with a 2-bit counter.
    - On the 4th byte, the next cycle asserts imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = BASE_ADDR + word_count.
    - word_count increments in the same cycle as the write.
    - rx_ready stays 1 during the write cycle. A byte accepted in the write cycle starts the next word, so there is no bubble.
    - After the Nth write, go to CHK (feature on) or RUN. No further bytes are accepted once the last byte has been taken.
  - RUN: cpu_run=1, load_done=1, rx_ready=0. Terminal until reset.
  - ERR: load_error=1, cpu_run=0, rx_ready=0. Terminal until reset.
- imem_addr holds its last value when imem_we=0. imem_wdata is don't-care when imem_we=0 but is held, not X.
- Bytes offered while rx_ready=0 are ignored; the loader does not consume them.
- rx_valid gaps of any length between bytes are allowed. Partial-word state is retained across gaps.
- Reset mid-load: the loader aborts immediately. Memory contents already written are not erased. The frame restarts at LEN_HI.
- Word count up to exactly the capacity is legal. The address never wraps, because oversize N is rejected in LEN_LO.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (excluding the length bytes) is kept.
  - After the last word, state CHK accepts one byte. If it equals the XOR, go to RUN; otherwise go to ERR.
  - With N=0 the expected checksum is 0x00.
- Undefined: no CHK state and no XOR logic. The FSM goes directly from the last write, or from N=0, to RUN.

Test Plan:
- Reset, then send 00 01 12 34 56 78 -> one imem_we pulse with addr=0 and wdata=0x12345678. Then cpu_run=1, load_done=1, word_count=1, rx_ready=0.
- Send N=3 with rx_valid toggling every other cycle, words 0x00000001/0x00000002/0x00000003 -> writes at addr 0,1,2 in order, exactly three imem_we pulses. cpu_run stays 0 until after the third write.
- Send length 01 01 (257) with ADDR_WIDTH=8, BASE_ADDR=0 -> ERR: load_error=1, rx_ready=0, no imem_we ever.
- Send N=0 (00 00) -> RUN with word_count=0 and no writes. With the feature on, it first requires checksum byte 00.
- Assert reset after 2 bytes of the 2nd word of an N=2 load, then send a full N=1 frame -> first write goes to addr 0, word_count=1, and no stale bytes appear in the data.
- Feature on: send N=1, data AA 55 0F F0, checksum 00 -> RUN. Repeat with checksum 01 -> ERR: load_error=1, cpu_run=0.
